// File: rtl/ls161_cascade.sv
// Chain of STAGES LS161-style 4-bit synchronous counters with an async clear, a sync load and an ENP/ENT carry chain.
// Define LS161_SYNC_CLR_EN to add the _SCLR input, which gives LS163-style synchronous clear.
module ls161_cascade #(
    parameter int STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  _CLR,
    input  logic                  _LOAD,
    input  logic                  ENP,
    input  logic                  ENT,
`ifdef LS161_SYNC_CLR_EN
    input  logic                  _SCLR,
`endif
    input  logic [4*STAGES-1:0]   D,
    output logic [4*STAGES-1:0]   Q,
    output logic [STAGES-1:0]     RCO_STAGE,
    output logic                  RCO
);

    localparam int W = 4 * STAGES;

    logic [W-1:0] q_next;

    function automatic logic [3:0] stage_next(
        input logic [3:0] q,
        input logic [3:0] d,
        input logic       load_n,
        input logic       inc
    );
        if (!load_n)
            return d;
        else if (inc)
            return q + 4'd1;
        else
            return q;
    endfunction

    // Carry ripples through the stages: stage k is enabled by the carry of stage k-1, and stage 0 by ENT.
    always_comb begin : carry_chain
        logic carry;
        carry     = ENT;
        RCO_STAGE = '0;
        q_next    = Q;
        for (int k = 0; k < STAGES; k++) begin
            q_next[4*k +: 4] = stage_next(Q[4*k +: 4], D[4*k +: 4], _LOAD, ENP & carry);
            carry            = carry & (Q[4*k +: 4] == 4'hF);
            RCO_STAGE[k]     = carry;
        end
`ifdef LS161_SYNC_CLR_EN
        if (!_SCLR)
            q_next = '0;
`endif
    end

    assign RCO = RCO_STAGE[STAGES-1];

    // Counter register stage
    always_ff @(posedge CLK or negedge _CLR) begin
        if (!_CLR)
            Q <= '0;
        else
            Q <= q_next;
    end

endmodule
